// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys fetched
// combinationally from the key-expansion stage via the registered round index.
module aes_encrypt_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] block_in,
    input  logic [127:0] cipher_key,
    input  logic         key_valid,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic         ready,
    output logic         valid_out,
    input  logic         out_ready,
    output logic [127:0] block_out
);

    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned RCNT_W     = 4;
    localparam int unsigned LAST_ROUND = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t              state;
    logic [BLOCK_W-1:0]  state_reg;
    logic [RCNT_W-1:0]   rcnt;
    logic [BLOCK_W-1:0]  sr_c;
    logic [BLOCK_W-1:0]  mc_c;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: byte (r,c) takes the S-box of byte (r,c+r mod 4).
    function automatic logic [BLOCK_W-1:0] sub_shift(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = SBOX[s[127 - 8*(r + 4*((c + r) % 4)) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 32*c - 8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 32*c - 24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign sr_c  = sub_shift(state_reg);
    assign mc_c  = mix_columns(sr_c);
    // rcnt is cleared outside rounds, so it doubles as the registered round index.
    assign round = rcnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            state_reg <= '0;
            rcnt      <= '0;
            ready     <= 1'b1;
            valid_out <= 1'b0;
            block_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && key_valid) begin
                        state_reg <= block_in ^ cipher_key;
                        rcnt      <= RCNT_W'(1);
                        ready     <= 1'b0;
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    if (rcnt == RCNT_W'(LAST_ROUND)) begin
                        block_out <= sr_c ^ round_key;
                        rcnt      <= '0;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state_reg <= mc_c ^ round_key;
                        rcnt      <= rcnt + RCNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_out <= 1'b0;
                        ready     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: FIPS-197 vectors, handshake corners and random
// blocks checked against a byte-level AES model built from GF(2^8) arithmetic.
module tb_aes_encrypt_core;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         key_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] block_in = '0;
    logic [127:0] cipher_key = '0;
    logic [127:0] round_key;
    logic [127:0] block_out;
    logic [3:0]   round;
    logic         ready;
    logic         valid_out;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk_tab [16];

    aes_encrypt_core dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .block_in   (block_in),
        .cipher_key (cipher_key),
        .key_valid  (key_valid),
        .round      (round),
        .round_key  (round_key),
        .ready      (ready),
        .valid_out  (valid_out),
        .out_ready  (out_ready),
        .block_out  (block_out)
    );

    always #5 clk = ~clk;

    // Key-expansion stage stand-in: combinational lookup by round index.
    assign round_key = (round >= 4'd1 && round <= 4'd10) ? rk_tab[round] : 128'd0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b} << k;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_round_key(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk;
        logic [127:0] o;
        rk = ref_round_key(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r + 4*c] = t[r + 4*((c + r) % 4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            rk = ref_round_key(key, rnd);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127 - 8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] key);
        cipher_key = key;
        for (int n = 0; n < 16; n++) rk_tab[n] = (n <= 10) ? ref_round_key(key, n) : 128'd0;
    endtask

    // One full block: accept, round sequence, result, optional backpressure, release.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp, input int hold);
        load_key(key);
        block_in  = pt;
        key_valid = 1'b1;
        out_ready = (hold == 0);
        start     = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_accept_ready"}, 128'(ready), 128'(0));
        check({tag, "_state_reg"}, dut.state_reg, pt ^ key);
        for (int k = 1; k <= 10; k++) begin
            check({tag, "_round"}, 128'(round), 128'(k));
            tick();
        end
        check({tag, "_valid"}, 128'(valid_out), 128'(1));
        check({tag, "_ct"}, block_out, exp);
        check({tag, "_round_end"}, 128'(round), 128'(0));
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            tick();
            check({tag, "_bp_valid"}, 128'(valid_out), 128'(1));
            check({tag, "_bp_ct"}, block_out, exp);
            check({tag, "_bp_ready"}, 128'(ready), 128'(0));
            check({tag, "_bp_round"}, 128'(round), 128'(0));
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, "_rel_valid"}, 128'(valid_out), 128'(0));
        check({tag, "_rel_ready"}, 128'(ready), 128'(1));
        check({tag, "_rel_ct"}, block_out, exp);
    endtask

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        logic [127:0] rkey, rpt;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        for (int n = 0; n < 16; n++) rk_tab[n] = '0;

        // Reset values
        #12;
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_valid", 128'(valid_out), 128'(0));
        check("rst_round", 128'(round), 128'(0));
        check("rst_block_out", block_out, 128'd0);
        check("rst_state_reg", dut.state_reg, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // FIPS-197 C.1 and B with out_ready high
        run_block("c1", C1_KEY, C1_PT, C1_CT, 0);
        run_block("fipsb", B_KEY, B_PT, B_CT, 0);

        // Backpressure with start pulses while DONE
        run_block("bp", C1_KEY, C1_PT, C1_CT, 5);

        // Key gating: start dropped while key_valid low
        load_key(B_KEY);
        block_in  = B_PT;
        key_valid = 1'b0;
        start     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gate_ready", 128'(ready), 128'(1));
            check("gate_round", 128'(round), 128'(0));
        end
        run_block("gate_go", B_KEY, B_PT, B_CT, 0);

        // Reset mid-run at round 5
        load_key(C1_KEY);
        block_in  = C1_PT;
        key_valid = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_round5", 128'(round), 128'(5));
        reset_n = 1'b0;
        #1;
        check("mid_ready", 128'(ready), 128'(1));
        check("mid_valid", 128'(valid_out), 128'(0));
        check("mid_round", 128'(round), 128'(0));
        check("mid_block_out", block_out, 128'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_block("post_rst", C1_KEY, C1_PT, C1_CT, 0);

        // Back-to-back with start held high
        load_key(C1_KEY);
        block_in  = C1_PT;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            check("b2b1_round", 128'(round), 128'(k));
            tick();
        end
        check("b2b1_valid", 128'(valid_out), 128'(1));
        check("b2b1_ct", block_out, C1_CT);
        tick();
        check("b2b_idle_ready", 128'(ready), 128'(1));
        check("b2b_idle_round", 128'(round), 128'(0));
        check("b2b_idle_valid", 128'(valid_out), 128'(0));
        load_key(B_KEY);
        block_in = B_PT;
        tick();
        check("b2b2_accept", 128'(ready), 128'(0));
        for (int k = 1; k <= 10; k++) begin
            check("b2b2_round", 128'(round), 128'(k));
            tick();
        end
        check("b2b2_valid", 128'(valid_out), 128'(1));
        check("b2b2_ct", block_out, B_CT);
        start = 1'b0;
        tick();
        check("b2b2_ready", 128'(ready), 128'(1));

        // Random blocks against the model
        for (int i = 0; i < 4; i++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rpt  = {$urandom, $urandom, $urandom, $urandom};
            run_block("rand", rkey, rpt, ref_encrypt(rkey, rpt), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
